// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the serial packed-BCD word adder.
package bcd_pkg;

    localparam int          DIGIT_W   = 4;
    localparam logic [4:0]  BCD_CORR  = 5'd6;
    localparam logic [4:0]  MAX_DIGIT = 5'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder with decimal carry and invalid-digit flag.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               ci,
    output logic [DIGIT_W-1:0] s,
    output logic               co,
    output logic               invalid
);

    logic [4:0] sum;
    logic [4:0] adj;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b} + {4'b0, ci};
        // Only the low nibble of the corrected sum is kept, giving the mod-16 wrap.
        adj     = sum + BCD_CORR;
        s       = sum[DIGIT_W-1:0];
        co      = 1'b0;
        if (sum > MAX_DIGIT) begin
            s  = adj[DIGIT_W-1:0];
            co = 1'b1;
        end
        invalid = ({1'b0, a} > MAX_DIGIT) || ({1'b0, b} > MAX_DIGIT);
    end

endmodule

// File: rtl/bcd_serial_word_adder.sv
// Digit-serial packed-BCD word adder: one digit per cycle, LSD first,
// result registers updated only when the whole word has been processed.
module bcd_serial_word_adder
    import bcd_pkg::*;
#(
    parameter int DIGIT_NUM = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [4*DIGIT_NUM-1:0]   A,
    input  logic [4*DIGIT_NUM-1:0]   B,
    input  logic                     Cin,
    output logic                     busy,
    output logic                     done,
    output logic [4*DIGIT_NUM-1:0]   S,
    output logic                     Cout,
    output logic                     err
);

    localparam int W  = DIGIT_W * DIGIT_NUM;
    localparam int CW = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1;

    state_t state_q, state_d;

    logic [W-1:0]          a_q, b_q, res_q;
    logic                  carry_q;
    logic                  err_acc_q;
    logic [CW-1:0]         cnt_q;

    logic [DIGIT_W-1:0]    dig_s;
    logic                  dig_co;
    logic                  dig_inv;
    logic                  last;
    logic [W+DIGIT_W-1:0]  res_cat;
    logic [W-1:0]          res_shift;

    bcd_digit_adder u_digit (
        .a       (a_q[DIGIT_W-1:0]),
        .b       (b_q[DIGIT_W-1:0]),
        .ci      (carry_q),
        .s       (dig_s),
        .co      (dig_co),
        .invalid (dig_inv)
    );

    // New digit enters at the top; after DIGIT_NUM shifts digit 0 sits in [3:0].
    always_comb begin
        res_cat   = {dig_s, res_q};
        res_shift = res_cat[W+DIGIT_W-1:DIGIT_W];
        last      = (cnt_q == CW'(DIGIT_NUM - 1));
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = ADD;
            ADD: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            err_acc_q <= 1'b0;
            cnt_q     <= '0;
            S         <= '0;
            Cout      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q       <= A;
                        b_q       <= B;
                        carry_q   <= Cin;
                        cnt_q     <= '0;
                        err_acc_q <= 1'b0;
                        res_q     <= '0;
                    end
                end
                ADD: begin
                    a_q       <= a_q >> DIGIT_W;
                    b_q       <= b_q >> DIGIT_W;
                    carry_q   <= dig_co;
                    cnt_q     <= cnt_q + CW'(1);
                    res_q     <= res_shift;
                    err_acc_q <= err_acc_q | dig_inv;
                    if (last) begin
                        S    <= res_shift;
                        Cout <= dig_co;
                        err  <= err_acc_q | dig_inv;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_word_adder.sv
// Directed, table-driven self-checking bench for bcd_serial_word_adder (DIGIT_NUM=8).
module tb_bcd_serial_word_adder;

    localparam int DN = 8;
    localparam int W  = 4 * DN;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  A, B;
    logic          Cin;
    logic          busy, done;
    logic [W-1:0]  S;
    logic          Cout, err;

    int total = 0;
    int bad   = 0;

    bcd_serial_word_adder #(.DIGIT_NUM(DN)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
        logic         err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start at edge 0; returns the edge index k at which done is seen (sampled just before edge k).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          output int lat);
        @(negedge clk);
        A = a; B = b; Cin = cin; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int lat;
    int done_cnt;

    initial begin
        vecs[0] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0};
        vecs[1] = '{32'h99999999, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h50000000, 32'h50000000, 1'b1, 32'h00000001, 1'b1, 1'b0};
        vecs[3] = '{32'h0000000A, 32'h00000000, 1'b0, 32'h00000010, 1'b0, 1'b1};
        vecs[4] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
        vecs[5] = '{32'h99999999, 32'h99999999, 1'b1, 32'h99999999, 1'b1, 1'b0};
        vecs[6] = '{32'hF0000000, 32'h00000000, 1'b0, 32'h50000000, 1'b1, 1'b1};
        vecs[7] = '{32'h0000000F, 32'h0000000F, 1'b0, 32'h00000014, 1'b0, 1'b1};
        vecs[8] = '{32'h00000005, 32'h00000005, 1'b0, 32'h00000010, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_S",    64'(S),    64'd0);
        chk("reset_Cout", 64'(Cout), 64'd0);
        chk("reset_err",  64'(err),  64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd9);
            chk($sformatf("v%0d_S", i),       64'(S),    64'(vecs[i].s));
            chk($sformatf("v%0d_Cout", i),    64'(Cout), 64'(vecs[i].cout));
            chk($sformatf("v%0d_err", i),     64'(err),  64'(vecs[i].err));
        end

        // Second start mid-operation with new operands must be ignored.
        @(negedge clk);
        A = 32'h12345678; B = 32'h87654321; Cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("ign_busy_k%0d", k), 64'(busy), 64'(k <= 8));
            chk($sformatf("ign_done_k%0d", k), 64'(done), 64'(k == 9));
            if (k == 9) begin
                chk("ign_S",    64'(S),    64'h99999999);
                chk("ign_Cout", 64'(Cout), 64'd0);
                chk("ign_err",  64'(err),  64'd0);
            end
            if (k == 2) begin
                A = 32'h0000000F; B = 32'h99999999; Cin = 1'b1; start = 1'b1;
            end
            if (k == 3) start = 1'b0;
        end

        // Back-to-back with start held high: accepts at edges 0 and 10.
        @(negedge clk);
        A = 32'h12345678; B = 32'h11111111; Cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        A = 32'h00000001; B = 32'h00000009;
        done_cnt = 0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_done_k%0d", k), 64'(done), 64'((k == 9) || (k == 19)));
            if (done) done_cnt++;
            if (k == 9)  chk("b2b_S1", 64'(S), 64'h23456789);
            if (k == 10) chk("b2b_busy_gap", 64'(busy), 64'd0);
            if (k == 11) chk("b2b_busy_second", 64'(busy), 64'd1);
            if (k == 19) begin
                chk("b2b_S2", 64'(S), 64'h00000010);
                start = 1'b0;
            end
        end
        chk("b2b_done_count", 64'(done_cnt), 64'd2);

        // Reset mid-operation: immediate clear, no done afterwards.
        @(negedge clk);
        A = 32'h12345678; B = 32'h87654321; Cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_S",    64'(S),    64'd0);
        chk("mid_rst_Cout", 64'(Cout), 64'd0);
        chk("mid_rst_err",  64'(err),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("mid_rst_no_done", 64'(done_cnt), 64'd0);
        run_op(32'h50000000, 32'h50000000, 1'b1, lat);
        chk("post_rst_latency", 64'(lat), 64'd9);
        chk("post_rst_S",       64'(S),    64'h00000001);
        chk("post_rst_Cout",    64'(Cout), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
